// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer bridging to a request/ack register backend.
// Optional APB_REG_SLAVE_TIMEOUT_EN adds a 16-cycle missing-ack timeout with PSLVERR.
module apb_reg_slave #(
   parameter int ADDR_W    = 8,
   parameter int REG_COUNT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   input  logic [3:0]        PSTRB,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              reg_wr,
   output logic              reg_rd,
   output logic [ADDR_W-3:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_strb,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_ack
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(REG_COUNT * 4);

   state_t            state_q, state_d;
   logic              pwrite_q, pwrite_d;
   logic              err_q, err_d;
   logic              nop_q, nop_d;
   logic [ADDR_W-3:0] reg_addr_q, reg_addr_d;
   logic [31:0]       reg_wdata_q, reg_wdata_d;
   logic [3:0]        reg_strb_q, reg_strb_d;
   logic              reg_wr_q, reg_wr_d;
   logic              reg_rd_q, reg_rd_d;
   logic [31:0]       prdata_q, prdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic              in_range;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
   logic [3:0]        cnt_q, cnt_d;
`endif

   assign in_range = ({1'b0, PADDR} < ADDR_LIMIT);

   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      err_d       = err_q;
      nop_d       = nop_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_strb_d  = reg_strb_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      prdata_d    = 32'h0;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d     = ST_REQ;
               pwrite_d    = PWRITE;
               err_d       = !in_range;
               nop_d       = PWRITE && (PSTRB == 4'b0000);
               reg_addr_d  = PADDR[ADDR_W-1:2];
               reg_wdata_d = PWDATA;
               reg_strb_d  = PSTRB;
               reg_wr_d    = PWRITE && in_range && (PSTRB != 4'b0000);
               reg_rd_d    = !PWRITE && in_range;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
               cnt_d       = 4'd0;
`endif
            end
         end
         ST_REQ, ST_WAIT: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
            end else if (err_q || nop_q) begin
               // No backend request was issued, so there is no ack to wait for.
               state_d   = ST_RESP;
               pready_d  = 1'b1;
               pslverr_d = err_q;
            end else if (reg_ack) begin
               state_d  = ST_RESP;
               pready_d = 1'b1;
               prdata_d = pwrite_q ? 32'h0 : reg_rdata;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
            end else if (state_q == ST_WAIT && cnt_q == 4'd15) begin
               state_d   = ST_RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
`endif
            end else begin
               state_d = ST_WAIT;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
               cnt_d   = cnt_q + 4'd1;
`endif
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pwrite_q    <= 1'b0;
         err_q       <= 1'b0;
         nop_q       <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 32'h0;
         reg_strb_q  <= 4'h0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         prdata_q    <= 32'h0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
         cnt_q       <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         pwrite_q    <= pwrite_d;
         err_q       <= err_d;
         nop_q       <= nop_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_strb_q  <= reg_strb_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         prdata_q    <= prdata_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign PRDATA    = prdata_q;
   assign PREADY    = pready_q;
   assign PSLVERR   = pslverr_q;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_strb  = reg_strb_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - directed self-checking bench for apb_reg_slave.
module tb_apb_reg_slave;

   logic        clk;
   logic        rst;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic        reg_wr, reg_rd;
   logic [5:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_strb;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   int checks = 0;
   int fails  = 0;

   apb_reg_slave #(.ADDR_W(8), .REG_COUNT(16)) dut (
      .clk(clk), .rst(rst),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_strb(reg_strb),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
   endtask

   task automatic release_bus();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({PRDATA, PREADY, PSLVERR, reg_wr, reg_rd} !== 36'h0) begin
         fails++;
         $display("FAIL reset_apb: PRDATA=%h PREADY=%b PSLVERR=%b wr=%b rd=%b required all 0",
                  PRDATA, PREADY, PSLVERR, reg_wr, reg_rd);
      end
      checks++;
      if ({reg_addr, reg_wdata, reg_strb} !== 42'h0) begin
         fails++;
         $display("FAIL reset_backend: addr=%h wdata=%h strb=%h required 0", reg_addr, reg_wdata, reg_strb);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      setup(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
      reg_ack = 1'b1;
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_wr, reg_rd, reg_addr, reg_wdata, reg_strb} !== {1'b1, 1'b0, 6'd1, 32'hDEADBEEF, 4'hF}) begin
         fails++;
         $display("FAIL write_req: wr=%b rd=%b addr=%h wdata=%h strb=%h required 1 0 01 deadbeef f",
                  reg_wr, reg_rd, reg_addr, reg_wdata, reg_strb);
      end
      checks++;
      if (PREADY !== 1'b0) begin
         fails++;
         $display("FAIL write_early_ready: PREADY=%b required 0", PREADY);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR, reg_wr, PRDATA} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL write_resp: PREADY=%b PSLVERR=%b wr=%b PRDATA=%h required 1 0 0 0",
                  PREADY, PSLVERR, reg_wr, PRDATA);
      end
      release_bus();
      reg_ack = 1'b0;
      tick();
      checks++;
      if (PREADY !== 1'b0) begin
         fails++;
         $display("FAIL write_ready_width: PREADY=%b required 0", PREADY);
      end
   endtask

   task automatic test_read_wait();
      int ready_cycles = 0;
      setup(1'b0, 8'h08, 32'h0, 4'h0);
      reg_ack = 1'b0;
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_rd, reg_wr, reg_addr} !== {1'b1, 1'b0, 6'd2}) begin
         fails++;
         $display("FAIL read_req: rd=%b wr=%b addr=%h required 1 0 02", reg_rd, reg_wr, reg_addr);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (PREADY === 1'b1 || reg_rd === 1'b1) ready_cycles++;
         if (i == 3) begin
            reg_ack   = 1'b1;
            reg_rdata = 32'h12345678;
         end
      end
      checks++;
      if (ready_cycles != 0) begin
         fails++;
         $display("FAIL read_wait_quiet: PREADY/reg_rd high in %0d wait cycles, required 0", ready_cycles);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'h12345678}) begin
         fails++;
         $display("FAIL read_resp: PREADY=%b PSLVERR=%b PRDATA=%h required 1 0 12345678",
                  PREADY, PSLVERR, PRDATA);
      end
      reg_ack   = 1'b0;
      reg_rdata = 32'hCAFEF00D;
      release_bus();
      tick();
      checks++;
      if ({PREADY, PRDATA} !== {1'b0, 32'h0}) begin
         fails++;
         $display("FAIL read_after: PREADY=%b PRDATA=%h required 0 0", PREADY, PRDATA);
      end
   endtask

   task automatic test_decode_error();
      setup(1'b0, 8'h40, 32'h0, 4'hF);
      reg_ack   = 1'b1;
      reg_rdata = 32'h55AA55AA;
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_rd, reg_wr} !== 2'b00) begin
         fails++;
         $display("FAIL decode_no_req: rd=%b wr=%b required 0 0", reg_rd, reg_wr);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b1, 32'h0}) begin
         fails++;
         $display("FAIL decode_resp: PREADY=%b PSLVERR=%b PRDATA=%h required 1 1 0",
                  PREADY, PSLVERR, PRDATA);
      end
      release_bus();
      reg_ack = 1'b0;
      tick();
      checks++;
      if (PSLVERR !== 1'b0) begin
         fails++;
         $display("FAIL decode_err_width: PSLVERR=%b required 0", PSLVERR);
      end
   endtask

   task automatic test_back_to_back();
      setup(1'b0, 8'h3C, 32'h0, 4'h0);
      reg_ack   = 1'b1;
      reg_rdata = 32'h0BADC0DE;
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_rd, reg_addr} !== {1'b1, 6'd15}) begin
         fails++;
         $display("FAIL b2b_last_reg_req: rd=%b addr=%h required 1 0f", reg_rd, reg_addr);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'h0BADC0DE}) begin
         fails++;
         $display("FAIL b2b_first_resp: PREADY=%b PSLVERR=%b PRDATA=%h required 1 0 0badc0de",
                  PREADY, PSLVERR, PRDATA);
      end
      tick();
      setup(1'b1, 8'h3C, 32'h11112222, 4'h0);
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_wr, reg_rd, reg_wdata} !== {1'b0, 1'b0, 32'h11112222}) begin
         fails++;
         $display("FAIL b2b_zero_strb_req: wr=%b rd=%b wdata=%h required 0 0 11112222",
                  reg_wr, reg_rd, reg_wdata);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL b2b_zero_strb_resp: PREADY=%b PSLVERR=%b PRDATA=%h required 1 0 0",
                  PREADY, PSLVERR, PRDATA);
      end
      release_bus();
      reg_ack = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int bad = 0;
      setup(1'b0, 8'h0C, 32'h0, 4'h0);
      reg_ack = 1'b0;
      tick();
      PENABLE = 1'b1;
      tick();
      release_bus();
      tick();
      checks++;
      if ({PREADY, PSLVERR, reg_rd} !== 3'b000) begin
         fails++;
         $display("FAIL abort_idle: PREADY=%b PSLVERR=%b rd=%b required 0 0 0", PREADY, PSLVERR, reg_rd);
      end
      reg_ack   = 1'b1;
      reg_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (PREADY !== 1'b0 || reg_rd !== 1'b0 || PRDATA !== 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL abort_late_ack: %0d cycles with activity, required 0", bad);
      end
      reg_ack = 1'b0;
   endtask

   task automatic test_async_reset();
      setup(1'b0, 8'h10, 32'h0, 4'h0);
      reg_ack = 1'b0;
      tick();
      PENABLE = 1'b1;
      tick();
      checks++;
      if (reg_addr !== 6'd4) begin
         fails++;
         $display("FAIL areset_pre: reg_addr=%h required 04", reg_addr);
      end
      #2;
      rst = 1'b0;
      release_bus();
      #1;
      checks++;
      if ({PRDATA, PREADY, PSLVERR, reg_wr, reg_rd, reg_addr, reg_wdata, reg_strb} !== 78'h0) begin
         fails++;
         $display("FAIL areset_outputs: PREADY=%b PSLVERR=%b rd=%b addr=%h required all 0",
                  PREADY, PSLVERR, reg_rd, reg_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      setup(1'b1, 8'h00, 32'hA5A5C3C3, 4'h3);
      reg_ack = 1'b1;
      tick();
      PENABLE = 1'b1;
      checks++;
      if ({reg_wr, reg_addr, reg_wdata, reg_strb} !== {1'b1, 6'd0, 32'hA5A5C3C3, 4'h3}) begin
         fails++;
         $display("FAIL areset_write_req: wr=%b addr=%h wdata=%h strb=%h required 1 00 a5a5c3c3 3",
                  reg_wr, reg_addr, reg_wdata, reg_strb);
      end
      tick();
      checks++;
      if ({PREADY, PSLVERR} !== 2'b10) begin
         fails++;
         $display("FAIL areset_write_resp: PREADY=%b PSLVERR=%b required 1 0", PREADY, PSLVERR);
      end
      release_bus();
      reg_ack = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n = 0;
      setup(1'b0, 8'h14, 32'h0, 4'h0);
      reg_ack = 1'b0;
      tick();
      PENABLE = 1'b1;
`ifdef APB_REG_SLAVE_TIMEOUT_EN
      while (n < 40) begin
         tick();
         n++;
         if (PREADY === 1'b1) break;
      end
      checks++;
      if (n != 16) begin
         fails++;
         $display("FAIL timeout_latency: PREADY after %0d cycles, required 16", n);
      end
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b1, 32'h0}) begin
         fails++;
         $display("FAIL timeout_resp: PREADY=%b PSLVERR=%b PRDATA=%h required 1 1 0",
                  PREADY, PSLVERR, PRDATA);
      end
`else
      for (int i = 0; i < 100; i++) begin
         tick();
         if (PREADY === 1'b1 || PSLVERR === 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         fails++;
         $display("FAIL no_timeout: PREADY/PSLVERR high in %0d of 100 cycles, required 0", n);
      end
`endif
      release_bus();
      tick();
      checks++;
      if ({PREADY, PSLVERR} !== 2'b00) begin
         fails++;
         $display("FAIL timeout_exit: PREADY=%b PSLVERR=%b required 0 0", PREADY, PSLVERR);
      end
   endtask

   initial begin
      rst = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 8'h0; PWDATA = 32'h0; PSTRB = 4'h0;
      reg_rdata = 32'h0; reg_ack = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_decode_error();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
